snax_wide_bank_splitter: RTL and testbench

- Sits directly upstream of the multi-bank local memory (NumBanks narrow SRAM banks, each behind an AMO shim and a 1-deep output pipeline register).
- Accepts one wide DMA request (valid/ready) and fans it out as NumBanks parallel narrow bank requests. While doing so it drives the DMA-access flag for the memory.
- Collects each bank's read data a fixed latency after that bank's handshake, then returns one reassembled wide response (valid/ready).

---
 rtl/snax_wide_bank_splitter.sv | 153 +++++++++++++++
 tb/tb_snax_wide_bank_splitter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snax_wide_bank_splitter.sv
// Wide-to-narrow bank request splitter: fans one wide DMA access out over NumBanks lanes
// and reassembles the read data. Optional stall counter under SNAX_WIDE_SPLITTER_PERF_EN.
module snax_wide_bank_splitter #(
    parameter int unsigned AddrWidth       = 48,
    parameter int unsigned NarrowDataWidth = 32,
    parameter int unsigned WideDataWidth   = 512,
    parameter int unsigned NumBanks        = WideDataWidth / NarrowDataWidth,
    parameter int unsigned RspLatency      = 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  wide_req_valid_i,
    output logic                                  wide_req_ready_o,
    input  logic [AddrWidth-1:0]                  wide_req_addr_i,
    input  logic                                  wide_req_write_i,
    input  logic [WideDataWidth-1:0]              wide_req_data_i,
    input  logic [WideDataWidth/8-1:0]            wide_req_strb_i,
    output logic                                  wide_rsp_valid_o,
    input  logic                                  wide_rsp_ready_i,
    output logic [WideDataWidth-1:0]              wide_rsp_data_o,
    output logic                                  dma_access_o,
    output logic [NumBanks-1:0]                   bank_q_valid_o,
    input  logic [NumBanks-1:0]                   bank_q_ready_i,
    output logic [NumBanks*AddrWidth-1:0]         bank_q_addr_o,
    output logic [NumBanks-1:0]                   bank_q_write_o,
    output logic [NumBanks*NarrowDataWidth-1:0]   bank_q_data_o,
    output logic [NumBanks*NarrowDataWidth/8-1:0] bank_q_strb_o,
`ifdef SNAX_WIDE_SPLITTER_PERF_EN
    input  logic                                  stall_clr_i,
    output logic [31:0]                           stall_cnt_o,
`endif
    input  logic [NumBanks*NarrowDataWidth-1:0]   bank_p_data_i
);

    // state   | meaning
    // IDLE    | ready for a wide request
    // ISSUE   | driving bank requests for lanes not yet accepted
    // COLLECT | all lanes accepted, waiting for the last read capture
    // RESP    | wide response presented until accepted
    typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, RESP} state_e;

    localparam int unsigned NarrowBytes = NarrowDataWidth / 8;
    localparam int unsigned WideBytes   = WideDataWidth / 8;
    localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(WideBytes - 1);

    state_e state_q, state_d;

    logic [AddrWidth-1:0]                   addr_q;
    logic                                   write_q;
    logic [WideDataWidth-1:0]               data_q;
    logic [WideBytes-1:0]                   strb_q;
    logic [NumBanks-1:0]                    done_q;
    logic [NumBanks-1:0]                    lane_en;
    logic [NumBanks-1:0]                    bank_hs;
    logic [RspLatency-1:0][NumBanks-1:0]    pend_q;
    logic [WideDataWidth-1:0]               rsp_data_q;
    logic                                   req_hs, rsp_hs, early_pend;

    assign wide_req_ready_o = (state_q == IDLE);
    assign wide_rsp_valid_o = (state_q == RESP);
    assign wide_rsp_data_o  = rsp_data_q;
    assign dma_access_o     = (state_q == ISSUE) || (state_q == COLLECT);
    assign req_hs           = wide_req_valid_i && wide_req_ready_o;
    assign rsp_hs           = wide_rsp_valid_o && wide_rsp_ready_i;

    assign bank_q_valid_o = (state_q == ISSUE) ? ~done_q : '0;
    assign bank_hs        = bank_q_valid_o & bank_q_ready_i;
    assign bank_q_write_o = {NumBanks{write_q}};
    assign bank_q_data_o  = data_q;
    assign bank_q_strb_o  = strb_q;

    for (genvar i = 0; i < NumBanks; i++) begin : g_lane
        assign lane_en[i] = |wide_req_strb_i[i*NarrowBytes +: NarrowBytes];
        assign bank_q_addr_o[i*AddrWidth +: AddrWidth] = addr_q + AddrWidth'(i * NarrowBytes);
    end

    // Captures still in flight beyond the one landing this cycle
    always_comb begin
        early_pend = 1'b0;
        for (int k = 0; k < int'(RspLatency) - 1; k++) begin
            early_pend = early_pend | (|pend_q[k]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_hs) state_d = ISSUE;
            ISSUE:   if (&(done_q | bank_hs)) state_d = write_q ? RESP : COLLECT;
            COLLECT: if (!early_pend) state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            data_q     <= '0;
            strb_q     <= '0;
            done_q     <= '0;
            pend_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (req_hs) begin
                addr_q  <= wide_req_addr_i & AlignMask;
                write_q <= wide_req_write_i;
                data_q  <= wide_req_data_i;
                strb_q  <= wide_req_strb_i;
                // write lanes without any strobe count as already accepted
                done_q  <= wide_req_write_i ? ~lane_en : '0;
            end else if (state_q == ISSUE) begin
                done_q <= done_q | bank_hs;
            end
            pend_q[0] <= write_q ? '0 : bank_hs;
            for (int k = 1; k < int'(RspLatency); k++) begin
                pend_q[k] <= pend_q[k-1];
            end
            if (rsp_hs) begin
                rsp_data_q <= '0;
            end else begin
                for (int i = 0; i < int'(NumBanks); i++) begin
                    if (pend_q[RspLatency-1][i]) begin
                        rsp_data_q[i*NarrowDataWidth +: NarrowDataWidth] <=
                            bank_p_data_i[i*NarrowDataWidth +: NarrowDataWidth];
                    end
                end
            end
        end
    end

`ifdef SNAX_WIDE_SPLITTER_PERF_EN
    logic [31:0] stall_cnt_q;
    logic        stall_now;

    assign stall_now   = |(bank_q_valid_o & ~bank_q_ready_i);
    assign stall_cnt_o = stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (stall_clr_i) begin
            stall_cnt_q <= '0;
        end else if (stall_now && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_snax_wide_bank_splitter.sv
// Bench for snax_wide_bank_splitter: bank/SRAM model plus a wide-line reference memory,
// directed scenarios followed by randomized traffic and backpressure.
module tb_snax_wide_bank_splitter;

    localparam int AW = 48;
    localparam int NW = 32;
    localparam int WW = 512;
    localparam int NB = 16;
    localparam int SB = WW / 8;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              wide_req_valid_i;
    logic              wide_req_ready_o;
    logic [AW-1:0]     wide_req_addr_i;
    logic              wide_req_write_i;
    logic [WW-1:0]     wide_req_data_i;
    logic [SB-1:0]     wide_req_strb_i;
    logic              wide_rsp_valid_o;
    logic              wide_rsp_ready_i;
    logic [WW-1:0]     wide_rsp_data_o;
    logic              dma_access_o;
    logic [NB-1:0]     bank_q_valid_o;
    logic [NB-1:0]     bank_q_ready_i;
    logic [NB*AW-1:0]  bank_q_addr_o;
    logic [NB-1:0]     bank_q_write_o;
    logic [NB*NW-1:0]  bank_q_data_o;
    logic [NB*NW/8-1:0] bank_q_strb_o;
    logic [NB*NW-1:0]  bank_p_data_i;
`ifdef SNAX_WIDE_SPLITTER_PERF_EN
    logic              stall_clr_i;
    logic [31:0]       stall_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    snax_wide_bank_splitter dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .wide_req_valid_i (wide_req_valid_i),
        .wide_req_ready_o (wide_req_ready_o),
        .wide_req_addr_i  (wide_req_addr_i),
        .wide_req_write_i (wide_req_write_i),
        .wide_req_data_i  (wide_req_data_i),
        .wide_req_strb_i  (wide_req_strb_i),
        .wide_rsp_valid_o (wide_rsp_valid_o),
        .wide_rsp_ready_i (wide_rsp_ready_i),
        .wide_rsp_data_o  (wide_rsp_data_o),
        .dma_access_o     (dma_access_o),
        .bank_q_valid_o   (bank_q_valid_o),
        .bank_q_ready_i   (bank_q_ready_i),
        .bank_q_addr_o    (bank_q_addr_o),
        .bank_q_write_o   (bank_q_write_o),
        .bank_q_data_o    (bank_q_data_o),
        .bank_q_strb_o    (bank_q_strb_o),
`ifdef SNAX_WIDE_SPLITTER_PERF_EN
        .stall_clr_i      (stall_clr_i),
        .stall_cnt_o      (stall_cnt_o),
`endif
        .bank_p_data_i    (bank_p_data_i)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bank-side SRAM and the wide-level reference memory, both 1024 words
    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];

    int          valid_cyc [NB];
    int          hs_cnt [NB];
    logic [NB-1:0] hs_mask;
    int          stall_lane = -1;
    int          stall_left = 0;
    bit          rdy_random = 1'b0;
    logic [AW-1:0] cur_aligned;
    logic        cur_write;
    logic [WW-1:0] cur_data;
    logic [SB-1:0] cur_strb;

    function automatic int ref_idx(input logic [AW-1:0] a, input int i);
        return (int'(a[11:2]) + i) & 1023;
    endfunction

    // Bank model: ready chosen at negedge, handshake sampled there, read data
    // presented one cycle after the handshake edge, junk otherwise.
    initial begin
        logic [NB-1:0] r, hs;
        int idx;
        bank_q_ready_i = '0;
        bank_p_data_i  = '0;
        forever begin
            @(negedge clk_i);
            for (int i = 0; i < NB; i++) begin
                r[i] = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (i == stall_lane && bank_q_valid_o[i] && stall_left > 0) begin
                    r[i] = 1'b0;
                    stall_left--;
                end
            end
            bank_q_ready_i = r;
            #1;
            hs = bank_q_valid_o & bank_q_ready_i & {NB{rst_ni}};
            for (int i = 0; i < NB; i++) begin
                if (bank_q_valid_o[i]) valid_cyc[i]++;
                if (hs[i]) begin
                    hs_cnt[i]++;
                    hs_mask[i] = 1'b1;
                    check_val("bank_addr", bank_q_addr_o[i*AW +: AW], cur_aligned + AW'(4 * i));
                    check_val("bank_write", bank_q_write_o[i], cur_write);
                    if (cur_write) begin
                        check_val("bank_wdata", bank_q_data_o[i*NW +: NW], cur_data[i*NW +: NW]);
                        check_val("bank_strb", bank_q_strb_o[i*4 +: 4], cur_strb[i*4 +: 4]);
                    end
                end
            end
            @(posedge clk_i);
            #1;
            for (int i = 0; i < NB; i++) begin
                idx = int'(bank_q_addr_o[i*AW+2 +: 10]);
                bank_p_data_i[i*NW +: NW] = $urandom;
                if (hs[i] && !bank_q_write_o[i]) begin
                    bank_p_data_i[i*NW +: NW] = mem[idx];
                end else if (hs[i]) begin
                    for (int b = 0; b < 4; b++)
                        if (bank_q_strb_o[i*4+b]) mem[idx][b*8 +: 8] = bank_q_data_o[i*NW+b*8 +: 8];
                end
            end
        end
    end

    task automatic run_txn(input logic [AW-1:0] addr, input logic wr, input logic [WW-1:0] data,
                           input logic [SB-1:0] strb, input int rsp_stall,
                           output int lat, output int dma_cyc, output logic [WW-1:0] rsp);
        logic [WW-1:0] exp;
        logic [NB-1:0] exp_mask;
        int guard, nhs;
        cur_aligned = addr & ~AW'(SB - 1);
        cur_write   = wr;
        cur_data    = data;
        cur_strb    = strb;
        exp = '0;
        for (int i = 0; i < NB; i++) begin
            exp_mask[i] = !wr || (strb[i*4 +: 4] != 4'h0);
            if (!wr) exp[i*NW +: NW] = ref_mem[ref_idx(cur_aligned, i)];
            valid_cyc[i] = 0;
            hs_cnt[i]    = 0;
        end
        hs_mask = '0;
        @(negedge clk_i);
        wide_req_valid_i = 1'b1;
        wide_req_addr_i  = addr;
        wide_req_write_i = wr;
        wide_req_data_i  = data;
        wide_req_strb_i  = strb;
        guard = 0;
        while (!wide_req_ready_o && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        check_val("req_ready_idle", wide_req_ready_o, 1'b1);
        @(posedge clk_i);
        #1;
        wide_req_valid_i = 1'b0;
        wide_req_data_i  = {16{$urandom}};
        lat = 0;
        dma_cyc = 0;
        do begin
            @(negedge clk_i);
            lat++;
            if (dma_access_o) dma_cyc++;
            if (!wide_rsp_valid_o) check_val("req_ready_busy", wide_req_ready_o, 1'b0);
        end while (!wide_rsp_valid_o && lat < 200);
        check_val("rsp_valid", wide_rsp_valid_o, 1'b1);
        check_val("rsp_data", wide_rsp_data_o, exp);
        rsp = wide_rsp_data_o;
        for (int s = 0; s < rsp_stall; s++) begin
            @(negedge clk_i);
            check_val("rsp_valid_hold", wide_rsp_valid_o, 1'b1);
            check_val("rsp_data_hold", wide_rsp_data_o, rsp);
        end
        check_val("req_ready_resp", wide_req_ready_o, 1'b0);
        wide_rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        wide_rsp_ready_i = 1'b0;
        @(negedge clk_i);
        check_val("req_ready_after", wide_req_ready_o, 1'b1);
        check_val("rsp_valid_after", wide_rsp_valid_o, 1'b0);
        check_val("rsp_data_cleared", wide_rsp_data_o, '0);
        check_val("dma_after", dma_access_o, 1'b0);
        check_val("lane_mask", hs_mask, exp_mask);
        nhs = 0;
        for (int i = 0; i < NB; i++) nhs += hs_cnt[i];
        check_val("lane_issue_total", nhs, $countones(exp_mask));
        if (wr) begin
            for (int i = 0; i < NB; i++)
                for (int b = 0; b < 4; b++)
                    if (strb[i*4+b]) ref_mem[ref_idx(cur_aligned, i)][b*8 +: 8] = data[i*NW+b*8 +: 8];
        end
    endtask

    initial begin
        int lat, dma;
        logic [WW-1:0] rsp, data, exp_a;
        logic [SB-1:0] strb;
        logic [31:0] v;

        rst_ni = 1'b0;
        wide_req_valid_i = 1'b0;
        wide_req_addr_i  = '0;
        wide_req_write_i = 1'b0;
        wide_req_data_i  = '0;
        wide_req_strb_i  = '0;
        wide_rsp_ready_i = 1'b0;
`ifdef SNAX_WIDE_SPLITTER_PERF_EN
        stall_clr_i = 1'b0;
`endif
        for (int k = 0; k < 1024; k++) begin
            v = (k < NB) ? 32'hA000_0000 + 32'(k) : $urandom;
            mem[k] = v;
            ref_mem[k] = v;
        end

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_val("rst_req_ready", wide_req_ready_o, 1'b1);
        check_val("rst_rsp_valid", wide_rsp_valid_o, 1'b0);
        check_val("rst_rsp_data", wide_rsp_data_o, '0);
        check_val("rst_dma", dma_access_o, 1'b0);
        check_val("rst_bank_valid", bank_q_valid_o, '0);
        rst_ni = 1'b1;

        // plain read, all banks ready
        run_txn(48'h1000, 1'b0, '0, '1, 0, lat, dma, rsp);
        for (int i = 0; i < NB; i++) exp_a[i*NW +: NW] = 32'hA000_0000 + 32'(i);
        check_val("rd_data_pattern", rsp, exp_a);
        check_val("rd_latency", lat, 3);
        check_val("rd_dma_cycles", dma, 2);
        check_val("rd_issue_cycles", valid_cyc[7], 1);

        // write touching only lanes 0 and 15
        for (int i = 0; i < NB; i++) data[i*NW +: NW] = $urandom;
        run_txn(48'h1000, 1'b1, data, 64'hF000_0000_0000_000F, 0, lat, dma, rsp);
        check_val("wr_lane_mask", hs_mask, 16'h8001);
        check_val("wr_latency", lat, 2);
        check_val("wr_dma_cycles", dma, 1);

        // write with no strobes: straight to response, no bank traffic
        run_txn(48'h1234, 1'b1, data, '0, 0, lat, dma, rsp);
        check_val("wr0_latency", lat, 2);
        check_val("wr0_lane_mask", hs_mask, '0);

        // lane 5 stalled for four cycles
        stall_lane = 5;
        stall_left = 4;
        run_txn(48'h1000, 1'b0, '0, '1, 0, lat, dma, rsp);
        stall_lane = -1;
        check_val("stall_lane5_valid", valid_cyc[5], 5);
        check_val("stall_lane0_valid", valid_cyc[0], 1);
        check_val("stall_latency", lat, 7);
`ifdef SNAX_WIDE_SPLITTER_PERF_EN
        check_val("stall_cnt", stall_cnt_o, 32'd4);
        stall_clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        stall_clr_i = 1'b0;
        check_val("stall_cnt_clr", stall_cnt_o, 32'd0);
`endif

        // response backpressure
        run_txn(48'h0C7F, 1'b0, '0, '1, 3, lat, dma, rsp);

        // reset while collecting
        @(negedge clk_i);
        cur_aligned = 48'h1000;
        cur_write   = 1'b0;
        wide_req_valid_i = 1'b1;
        wide_req_addr_i  = 48'h1000;
        wide_req_write_i = 1'b0;
        wide_req_strb_i  = '1;
        @(posedge clk_i);
        #1;
        wide_req_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check_val("pre_rst_dma", dma_access_o, 1'b1);
        check_val("pre_rst_bank_valid", bank_q_valid_o, '0);
        rst_ni = 1'b0;
        #1;
        check_val("arst_req_ready", wide_req_ready_o, 1'b1);
        check_val("arst_rsp_valid", wide_rsp_valid_o, 1'b0);
        check_val("arst_rsp_data", wide_rsp_data_o, '0);
        check_val("arst_dma", dma_access_o, 1'b0);
        check_val("arst_bank_valid", bank_q_valid_o, '0);
        @(posedge clk_i);
        #1;
        check_val("arst_hold_rsp_valid", wide_rsp_valid_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_txn(48'h2040, 1'b0, '0, '1, 0, lat, dma, rsp);
        check_val("post_rst_latency", lat, 3);

        // randomized traffic with random bank readiness and response stalls
        rdy_random = 1'b1;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NB; i++) data[i*NW +: NW] = $urandom;
            case ($urandom_range(0, 3))
                0: strb = '1;
                1: strb = {$urandom, $urandom};
                2: strb = '0;
                default: begin
                    strb = '0;
                    strb[$urandom_range(0, NB-1)*4 +: 4] = 4'($urandom_range(1, 15));
                end
            endcase
            run_txn(AW'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)), data, strb,
                    $urandom_range(0, 2), lat, dma, rsp);
        end
        rdy_random = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
